// File: rtl/spi_ad_pkg.sv
// Shared types and helpers for the ADC/DDC configuration SPI master.
package spi_ad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // One frame is the R/W bit followed by the address and data fields.
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period timing: strobes mark the clk edge that ends a low half
// (rise_en) or a high half (fall_en). Runs only while en is high.
module spi_sclk_gen
  import spi_ad_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_en,
  output logic fall_en
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          phase;     // 0 = low half, 1 = high half
  logic          half_end;

  // Divider counter and half-period phase; parked at the start of a low half when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign half_end = en && (div_cnt == DIV_LAST);
  assign rise_en  = half_end && !phase;
  assign fall_en  = half_end && phase;

endmodule

// File: rtl/spi_ad_master.sv
// SPI master for converter configuration ports: one R/W + address + data
// frame per request, MSB first, mode 0, 3-wire or 4-wire readback.
module spi_ad_master
  import spi_ad_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              csb,
  output logic              sclk,
  output logic              sdi,
  output logic              sdi_oe,
  input  logic              sdo
);

  localparam int N    = frame_len(ADDR_W, DATA_W);
  localparam int BW   = cnt_w(N + 1);
  localparam int PMAX = (CS_SETUP > CS_HOLD) ?
                        ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP) :
                        ((CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP);
  localparam int PW   = cnt_w(PMAX);

  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(IDLE_GAP - 1);
  localparam logic [BW-1:0] ADDR_LAST  = BW'(ADDR_W);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

  state_t            state;
  logic [PW-1:0]     cnt;       // cycles spent in SETUP / HOLD / GAP
  logic [BW-1:0]     bit_cnt;   // index of the bit currently on the wire
  logic [N-2:0]      shreg;     // bits still to send after the one on sdi
  logic              rw_q;
  logic [DATA_W-1:0] cap;
  logic              shift_en;
  logic              rise_en;
  logic              fall_en;

  assign shift_en = (state == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (shift_en),
    .rise_en(rise_en),
    .fall_en(fall_en)
  );

  // Frame sequencer; every pin and status output is a register of this block.
  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rw_q    <= RW_WRITE;
      cap     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      csb     <= 1'b1;
      sclk    <= 1'b0;
      sdi     <= 1'b0;
      sdi_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped on purpose.
          if (start && !done) begin
            rw_q   <= rw;
            shreg  <= {addr, wdata};
            busy   <= 1'b1;
            csb    <= 1'b0;
            sdi    <= rw;
            sdi_oe <= 1'b1;
            cnt    <= '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        SHIFT: begin
          if (rise_en) sclk <= 1'b1;
          if (fall_en) begin
            sclk  <= 1'b0;
            shreg <= {shreg[N-3:0], 1'b0};
            if (rw_q == RW_READ && bit_cnt > ADDR_LAST)
              cap <= {cap[DATA_W-2:0], sdo};
            // On a read the pad turns around once the address is out.
            if (rw_q == RW_READ && bit_cnt >= ADDR_LAST) begin
              sdi    <= 1'b0;
              sdi_oe <= 1'b0;
            end else begin
              sdi <= shreg[N-2];
            end
            if (bit_cnt == BIT_LAST) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt    <= '0;
            csb    <= 1'b1;
            sdi    <= 1'b0;
            sdi_oe <= 1'b0;
            state  <= GAP;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rw_q == RW_READ) rdata <= cap;
            state <= IDLE;
          end else begin
            cnt <= cnt + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ad_master.sv
// Scoreboard bench for spi_ad_master: a device model answers reads from a
// register map, a monitor measures each frame on the pins and compares it
// with the expectation queued when the request was issued.
module tb_spi_ad_master;

  localparam int AW   = 15;
  localparam int DW   = 8;
  localparam int CD   = 2;
  localparam int CSS  = 2;
  localparam int CSH  = 2;
  localparam int IGAP = 2;
  localparam int N    = 1 + AW + DW;
  localparam int LAT  = 1 + CSS + 2 * CD * N + CSH + IGAP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, csb, sclk, sdi, sdi_oe;
  logic [DW-1:0] rdata;
  logic          sdo = 1'b0;
  logic          sweep_go = 1'b0;

  spi_ad_master #(
    .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(CD),
    .CS_SETUP(CSS), .CS_HOLD(CSH), .IDLE_GAP(IGAP)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .csb(csb), .sclk(sclk),
    .sdi(sdi), .sdi_oe(sdi_oe), .sdo(sdo)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            chk_gap;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] dev_mem[int];
  logic [DW-1:0] model_rdata;

  // Monitor state (written only by the monitor process).
  logic          prev_sclk = 1'b0, prev_busy = 1'b0, frame_rw = 1'b0, hi_bit = 1'b0;
  logic [N-1:0]  bits = '0;
  logic [AW-1:0] dev_addr = '0;
  logic [DW-1:0] dev_val = '0;
  logic [DW-1:0] rdata_cur = '0;
  longint        t_first = 0;
  int            rises = 0, falls = 0, csb_low = 0, gap_run = 0, last_gap = 0;
  int            oe_err = 0, stab_err = 0, hold_err = 0;
  exp_t          e;

  // Device model and pin monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_sclk = 1'b0; prev_busy = 1'b0; rdata_cur = '0; sdo = 1'b0;
      gap_run = 0; hold_err = 0; rises = 0; falls = 0;
    end else begin
      if (busy && !prev_busy) begin
        t_first = cyc; rises = 0; falls = 0; bits = '0;
        oe_err = 0; stab_err = 0; csb_low = 0;
      end
      if (csb) gap_run++;
      else begin
        if (gap_run > 0) last_gap = gap_run;
        gap_run = 0;
        csb_low++;
      end
      if (sclk && !prev_sclk) begin
        rises++;
        bits = {bits[N-2:0], sdi};
        hi_bit = sdi;
        if (rises == 1) frame_rw = sdi;
        if (sdi_oe !== ((rises <= 1 + AW) || !frame_rw)) oe_err++;
      end else if (sclk && prev_sclk && sdi !== hi_bit) begin
        stab_err++;
      end
      if (!sclk && prev_sclk) begin
        falls++;
        // The device starts driving read data after the last address bit.
        if (frame_rw && falls >= AW + 1 && falls <= AW + DW) begin
          if (falls == AW + 1) begin
            dev_addr = bits[AW-1:0];
            dev_val  = dev_mem.exists(int'(dev_addr)) ? dev_mem[int'(dev_addr)] : '0;
          end
          sdo = dev_val[DW - 1 - (falls - AW - 1)];
        end else begin
          sdo = 1'b0;
        end
      end
      if (busy && frame_rw && falls >= AW + 1 && sdi_oe) oe_err++;
      if (!done && rdata !== rdata_cur) hold_err++;
      if (done) begin
        check("done_has_request", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("latency", cyc - t_first + 1, LAT);
          check("sclk_pulses", rises, N);
          check("csb_low_cycles", csb_low, CSS + 2 * CD * N + CSH);
          check("frame_header", bits[N-1:DW], {e.rw, e.addr});
          if (!e.rw) check("frame_wdata", bits[DW-1:0], e.wdata);
          check("rdata", rdata, e.rdata);
          check("sdi_oe_profile_errs", oe_err, 0);
          check("sdi_stability_errs", stab_err, 0);
          check("rdata_hold_errs", hold_err, 0);
          // csb high: GAP cycles, the done cycle, and the accepting cycle.
          if (e.chk_gap) check("csb_gap", last_gap, IGAP + 2);
          rdata_cur = e.rdata;
          hold_err  = 0;
        end
      end
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  // Issue one request (called between a negedge and the next posedge).
  task automatic issue(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit chk_gap);
    rw = r; addr = a; wdata = d; start = 1'b1;
    if (r) model_rdata = dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : '0;
    exp_q.push_back('{r, a, d, model_rdata, chk_gap});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_within_budget", seen, 1'b1);
  endtask

  // Parameter sweep: CLK_DIV 1 and 4 with a 6-bit address and 16-bit data.
  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int SCD  = (g == 0) ? 1 : 4;
    localparam int SN   = 23;
    localparam int SLAT = 1 + CSS + 2 * SCD * SN + CSH + IGAP;

    typedef struct {
      logic        rw;
      logic [5:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
    } sexp_t;

    sexp_t       q[$];
    logic        s_start = 1'b0, s_rw = 1'b0, fin = 1'b0;
    logic [5:0]  s_addr = '0;
    logic [15:0] s_wdata = '0;
    logic        s_busy, s_done, s_csb, s_sclk, s_sdi, s_sdi_oe;
    logic [15:0] s_rdata;

    spi_ad_master #(
      .ADDR_W(6), .DATA_W(16), .CLK_DIV(SCD),
      .CS_SETUP(CSS), .CS_HOLD(CSH), .IDLE_GAP(IGAP)
    ) u_dut (
      .clk(clk), .rst(rst), .start(s_start), .rw(s_rw), .addr(s_addr), .wdata(s_wdata),
      .busy(s_busy), .done(s_done), .rdata(s_rdata), .csb(s_csb), .sclk(s_sclk),
      .sdi(s_sdi), .sdi_oe(s_sdi_oe), .sdo(1'b1)
    );

    logic        p_sclk = 1'b0, p_busy = 1'b0;
    logic [22:0] s_bits = '0;
    longint      s_first = 0, last_rise = 0;
    int          s_rises = 0, per_err = 0, hi_cnt = 0, hi_err = 0;
    sexp_t       se;

    // Sweep monitor: sclk period and high time, pulse count, latency, payload.
    always @(negedge clk) begin
      if (!rst) begin
        p_sclk = 1'b0; p_busy = 1'b0; hi_cnt = 0;
      end else begin
        if (s_busy && !p_busy) begin
          s_first = cyc; s_rises = 0; per_err = 0; hi_err = 0; hi_cnt = 0; s_bits = '0;
        end
        if (s_sclk) hi_cnt++;
        if (s_sclk && !p_sclk) begin
          if (s_rises > 0 && (cyc - last_rise) != 2 * SCD) per_err++;
          last_rise = cyc;
          s_rises++;
          s_bits = {s_bits[21:0], s_sdi};
        end
        if (!s_sclk && p_sclk) begin
          if (hi_cnt != SCD) hi_err++;
          hi_cnt = 0;
        end
        if (s_done) begin
          check("sweep_done_has_request", q.size() != 0, 1'b1);
          if (q.size() != 0) begin
            se = q.pop_front();
            check("sweep_latency", cyc - s_first + 1, SLAT);
            check("sweep_sclk_pulses", s_rises, SN);
            check("sweep_period_errs", per_err, 0);
            check("sweep_high_time_errs", hi_err, 0);
            check("sweep_header", s_bits[22:16], {se.rw, se.addr});
            if (!se.rw) check("sweep_wdata", s_bits[15:0], se.wdata);
            check("sweep_rdata", s_rdata, se.rdata);
          end
        end
        p_sclk = s_sclk;
        p_busy = s_busy;
      end
    end

    // Sweep stimulus: write, read (sdo tied high), write.
    initial begin
      logic [15:0] m_rd;
      bit          seen;
      m_rd = '0;
      wait (sweep_go);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        s_rw    = (k == 1);
        s_addr  = 6'($urandom);
        s_wdata = 16'($urandom);
        s_start = 1'b1;
        if (s_rw) m_rd = 16'hFFFF;
        q.push_back('{s_rw, s_addr, s_wdata, m_rd});
        @(negedge clk);
        s_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          seen = s_done;
        end
        check("sweep_done_within_budget", seen, 1'b1);
      end
      fin = 1'b1;
    end
  end

  initial begin
    logic          r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            swept;
    model_rdata = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_csb", csb, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_sdi_oe", sdi_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, '0);
    rst = 1'b1;

    // Directed write and read.
    @(negedge clk);
    issue(1'b0, 15'h0014, 8'hA5, 1'b0);
    wait_done(200);
    @(negedge clk);
    dev_mem[1] = 8'h3C;
    issue(1'b1, 15'h0001, 8'h00, 1'b0);
    wait_done(200);

    // Start mid-frame and in the done cycle: both dropped; next cycle accepted.
    @(negedge clk);
    issue(1'b0, 15'h0123, 8'h5E, 1'b0);
    repeat (49) @(negedge clk);
    rw = 1'b1; addr = 15'h7FFF; wdata = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    rw = 1'b0; addr = 15'h2222; wdata = 8'h81; start = 1'b1;
    @(negedge clk);
    issue(1'b0, 15'h2222, 8'h81, 1'b1);
    wait_done(200);

    // Back-to-back reads returning all ones then all zeros.
    @(negedge clk);
    dev_mem[10] = 8'hFF;
    dev_mem[11] = 8'h00;
    issue(1'b1, 15'd10, 8'h00, 1'b0);
    wait_done(200);
    @(negedge clk);
    issue(1'b1, 15'd11, 8'h00, 1'b1);
    wait_done(200);

    // Randomized requests.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      r = 1'($urandom);
      a = AW'($urandom);
      d = DW'($urandom);
      if (r) dev_mem[int'(a)] = DW'($urandom);
      issue(r, a, d, 1'b0);
      wait_done(200);
    end

    // Reset in the middle of a read after a nonzero readback.
    @(negedge clk);
    dev_mem[3] = 8'h5A;
    issue(1'b1, 15'd3, 8'h00, 1'b0);
    wait_done(200);
    @(negedge clk);
    issue(1'b1, 15'd3, 8'h00, 1'b0);
    repeat (39) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_csb", csb, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rdata", rdata, '0);
    check("abort_sdi_oe", sdi_oe, 1'b0);
    exp_q.delete();
    model_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (150) @(negedge clk);
    dev_mem[5] = 8'hC3;
    issue(1'b1, 15'd5, 8'h00, 1'b0);
    wait_done(200);

    // Parameter sweep instances.
    sweep_go = 1'b1;
    swept = 1'b0;
    for (int i = 0; i < 3000 && !swept; i++) begin
      @(negedge clk);
      swept = sw[0].fin && sw[1].fin;
    end
    check("sweep_finished", swept, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
